// File: rtl/tl_light_monitor.sv
// tl_light_monitor
// Watches the light codes on roads A and B, rebuilds the controller's 3-bit
// state, and flags illegal patterns, illegal steps and over-long yellows.
// The yellow pairs 001/011 and 101/111 look identical on the lights, so
// they can only be told apart by remembering the state that came before.
module tl_light_monitor #(
  parameter int MAX_YELLOW = 3,
  parameter int DWELL_W    = 8,
  parameter int CNT_W      = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [1:0]         La,
  input  logic [1:0]         Lb,
  output logic [2:0]         q_rec,
  output logic               valid,
  output logic               err,
  output logic [1:0]         err_code,
  output logic [DWELL_W-1:0] dwell,
  output logic [CNT_W-1:0]   cycles,
  output logic [CNT_W-1:0]   err_cnt
);

  // Tracker states: 0..7 mean "locked to controller state s", 8 means SYNC.
  localparam logic [3:0] ST_SYNC = 4'd8;

  localparam logic [1:0] EC_NONE  = 2'b00;
  localparam logic [1:0] EC_PAT   = 2'b01;
  localparam logic [1:0] EC_TRANS = 2'b10;
  localparam logic [1:0] EC_YEL   = 2'b11;

  localparam logic [DWELL_W-1:0] DWELL_MAX  = {DWELL_W{1'b1}};
  localparam logic [DWELL_W-1:0] YEL_LIMIT  = DWELL_W'(MAX_YELLOW);
  localparam logic [CNT_W-1:0]   ERRCNT_MAX = {CNT_W{1'b1}};

  // Light pattern {La, Lb} the controller shows in state s.
  function automatic logic [3:0] pattern_of(input logic [2:0] s);
    logic [3:0] p;
    case (s)
      3'd0:    p = 4'b0011;
      3'd1:    p = 4'b0111;
      3'd2:    p = 4'b1011;
      3'd3:    p = 4'b0111;
      3'd4:    p = 4'b1100;
      3'd5:    p = 4'b1101;
      3'd6:    p = 4'b1110;
      3'd7:    p = 4'b1101;
      default: p = 4'b0011;
    endcase
    return p;
  endfunction

  // True for the six patterns any controller state can produce.
  function automatic logic pattern_legal(input logic [3:0] p);
    logic ok;
    case (p)
      4'b0011, 4'b0111, 4'b1011,
      4'b1100, 4'b1101, 4'b1110: ok = 1'b1;
      default:                   ok = 1'b0;
    endcase
    return ok;
  endfunction

  // True for the two shared (ambiguous) yellow patterns.
  function automatic logic pattern_yellow(input logic [3:0] p);
    return (p == 4'b0111) || (p == 4'b1101);
  endfunction

  // Unique state behind a non-yellow pattern.
  function automatic logic [2:0] lock_state(input logic [3:0] p);
    logic [2:0] s;
    case (p)
      4'b0011: s = 3'd0;
      4'b1011: s = 3'd2;
      4'b1100: s = 3'd4;
      4'b1110: s = 3'd6;
      default: s = 3'd0;
    endcase
    return s;
  endfunction

  logic [3:0]         fsm_r;
  logic [3:0]         fsm_nxt_s;
  logic [2:0]         q_nxt_s;
  logic               valid_nxt_s;
  logic [DWELL_W-1:0] dwell_nxt_s;
  logic [CNT_W-1:0]   cycles_nxt_s;
  logic               err_s;
  logic [1:0]         code_s;

  logic [3:0] pat_s;
  logic [2:0] cur_s;
  logic [2:0] succ_s;

  assign pat_s  = {La, Lb};
  assign cur_s  = fsm_r[2:0];
  assign succ_s = cur_s + 3'd1;

  // Decode one sample: pick the next tracker state and flag any violation.
  always_comb begin
    fsm_nxt_s    = fsm_r;
    q_nxt_s      = q_rec;
    valid_nxt_s  = valid;
    dwell_nxt_s  = dwell;
    cycles_nxt_s = cycles;
    err_s        = 1'b0;
    code_s       = EC_NONE;

    if (!pattern_legal(pat_s)) begin
      err_s       = 1'b1;
      code_s      = EC_PAT;
      fsm_nxt_s   = ST_SYNC;
      valid_nxt_s = 1'b0;
      dwell_nxt_s = '0;
    end else if (fsm_r == ST_SYNC) begin
      if (pattern_yellow(pat_s)) begin
        // A yellow alone cannot say which of its two states we are in.
        valid_nxt_s = 1'b0;
        dwell_nxt_s = '0;
      end else begin
        fsm_nxt_s   = {1'b0, lock_state(pat_s)};
        q_nxt_s     = lock_state(pat_s);
        valid_nxt_s = 1'b1;
        dwell_nxt_s = '0;
      end
    end else if (pat_s == pattern_of(cur_s)) begin
      if (cur_s[0] && (dwell == YEL_LIMIT)) begin
        err_s       = 1'b1;
        code_s      = EC_YEL;
        fsm_nxt_s   = ST_SYNC;
        valid_nxt_s = 1'b0;
        dwell_nxt_s = '0;
      end else begin
        dwell_nxt_s = (dwell == DWELL_MAX) ? dwell : dwell + DWELL_W'(1);
      end
    end else if (pat_s == pattern_of(succ_s)) begin
      fsm_nxt_s   = {1'b0, succ_s};
      q_nxt_s     = succ_s;
      dwell_nxt_s = '0;
      if (cur_s == 3'd7) begin
        cycles_nxt_s = cycles + CNT_W'(1);
      end else begin
        cycles_nxt_s = cycles;
      end
    end else begin
      err_s       = 1'b1;
      code_s      = EC_TRANS;
      fsm_nxt_s   = ST_SYNC;
      valid_nxt_s = 1'b0;
      dwell_nxt_s = '0;
    end
  end

  // Register the tracker state and every output.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fsm_r    <= ST_SYNC;
      q_rec    <= 3'd0;
      valid    <= 1'b0;
      err      <= 1'b0;
      err_code <= EC_NONE;
      dwell    <= '0;
      cycles   <= '0;
      err_cnt  <= '0;
    end else begin
      fsm_r  <= fsm_nxt_s;
      q_rec  <= q_nxt_s;
      valid  <= valid_nxt_s;
      err    <= err_s;
      dwell  <= dwell_nxt_s;
      cycles <= cycles_nxt_s;
      if (err_s) begin
        err_code <= code_s;
        err_cnt  <= (err_cnt == ERRCNT_MAX) ? err_cnt : err_cnt + CNT_W'(1);
      end else begin
        err_code <= err_code;
        err_cnt  <= err_cnt;
      end
    end
  end

endmodule

// File: doc/tl_light_monitor.md
# tl_light_monitor

Sequence monitor and state decoder for the two-road traffic light controller with left-turn phases. Each clock it samples the light codes driven onto roads A and B and reconstructs the controller's 3-bit state. It checks every step against the legal phase sequence and the yellow dwell limit, and flags any violation. It sits beside the controller as an in-system checker and doubles as the bench scoreboard.

## Interface
- `MAX_YELLOW`, default 3: maximum number of extra cycles a yellow state may be held after entry.
- `DWELL_W`, default 8: width of `dwell`.
- `CNT_W`, default 8: width of `cycles` and `err_cnt`.

Ports:
- `clk`  in  1  clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `La`  in  2  road A light code: 00 green, 01 yellow, 10 left, 11 red.
- `Lb`  in  2  road B light code, same encoding as `La`.
- `q_rec`  out  3  reconstructed controller state.
- `valid`  out  1  `q_rec` is locked and trustworthy.
- `err`  out  1  one-cycle pulse on a detected violation.
- `err_code`  out  2  cause of the last error, held until the next error: 01 illegal pattern, 10 illegal transition, 11 yellow timeout.
- `dwell`  out  DWELL_W  cycles the current state has been held; saturates.
- `cycles`  out  CNT_W  count of completed full rotations; wraps.
- `err_cnt`  out  CNT_W  total errors; saturates at all-ones.

## Operation

State-to-pattern map, written as (La, Lb):
- 000: (00, 11)
- 001: (01, 11)
- 010: (10, 11)
- 011: (01, 11)
- 100: (11, 00)
- 101: (11, 01)
- 110: (11, 10)
- 111: (11, 01)

Legal sequence: 000→001→010→011→100→101→110→111→000. A self-hold is legal in every state.

Ambiguity: 001 and 011 share a pattern, and so do 101 and 111. These pairs are resolved only through history, so the monitor is an FSM with nine states: SYNC plus the eight TRACK(s) states.

Decode rules, applied in priority order each edge:
- **Illegal pattern.** A pattern outside the six distinct ones, for example both roads non-red or (11, 11), gives error code 01 from any FSM state.
- **SYNC.**
  - Non-yellow pattern: lock to its unique state (000/010/100/110), `valid`=1, `dwell`=0.
  - Yellow pattern: remain in SYNC, `valid`=0, no error.
- **TRACK(s), pattern equals P(s).** Hold: `dwell` increments, saturating at 2^DWELL_W−1.
  - If s is yellow (001/011/101/111) and `dwell`==MAX_YELLOW before the increment, raise error code 11.
- **TRACK(s), pattern equals P(s+1 mod 8).** Advance to s+1 and set `dwell`=0.
  - On the 111→000 advance, `cycles` increments.
- **TRACK(s), any other legal pattern.** Error code 10.

On any error in that cycle:
- `err`=1, `err_code` updated, `err_cnt` increments (saturating).
- FSM goes to SYNC: `valid`=0, `dwell`=0, `q_rec` holds its last value.
- The following sample is evaluated under the SYNC rules. An illegal pattern that stays on the inputs produces an error every cycle.

## Timing
- All outputs are registered. The sample taken at edge k is reflected in the outputs immediately after edge k: one-cycle latency from the light codes to the outputs.
- `err` is high for exactly the cycle following the offending edge.
- Reset values: `q_rec`=000, `valid`=0, `err`=0, `err_code`=00, `dwell`=0, `cycles`=0, `err_cnt`=0, FSM=SYNC.
- Asserting `reset` in the middle of a sequence clears everything immediately and asynchronously. The first edge after deassertion is evaluated under the SYNC rules.
- Width rules:
  - `dwell` saturates and never wraps.
  - `cycles` wraps from 2^CNT_W−1 to 0.
  - `err_cnt` sticks at 2^CNT_W−1.

## Test plan
- **Full rotation.** Reset, then drive each state's pattern for 2 cycles, starting at (00, 11). Required: `q_rec` steps 000…111 with `valid`=1 from the first edge; `dwell` alternates 0/1; `cycles`=1 after the return to (00, 11); `err` is never asserted.
- **Yellow ambiguity.** Reset, then (01, 11) for 3 cycles, then (10, 11). Required: `valid`=0 and `q_rec`=000 during the yellows, then `valid`=1 and `q_rec`=010. Next drive (01, 11). Required: `q_rec`=011, not 001.
- **Illegal pattern.** Locked at 000, drive (00, 00). Required: `err` is a one-cycle pulse, `err_code`=01, `err_cnt`=1, `valid`=0. Then drive (11, 00). Required: relock at 100.
- **Illegal transition.** Locked at 000, drive (11, 00). Required: `err_code`=10, `valid`=0. The next (11, 00) sample relocks to 100.
- **Yellow timeout** (MAX_YELLOW=3). From 000, drive (01, 11) for 5 samples. Required: samples 1–4 give `dwell` 0,1,2,3; sample 5 gives `err`=1 and `err_code`=11.
- **Reset and saturation.**
  - Assert `reset` between edges while at 101. Required: all outputs clear immediately, without waiting for a clock edge.
  - With CNT_W=2, inject 5 illegal patterns. Required: `err_cnt` holds at 3.
